// File: rtl/path_extractor_pkg.sv
// Shared types for the path extractor: FSM state encoding and the stack-pointer width helper.
package path_extractor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StWait,
    StPush,
    StEmit,
    StDone,
    StError
  } state_e;

  // The stack pointer must be able to count 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/path_extractor_if.sv
// Node-stream handshake between the path extractor (master) and its consumer (slave).
interface path_extractor_if #(
  parameter int unsigned INDEX_WIDTH = 4
) ();

  logic                   path_valid;
  logic                   path_ready;
  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_last;

  modport master (
    output path_valid,
    output path_node,
    output path_last,
    input  path_ready
  );

  modport slave (
    input  path_valid,
    input  path_node,
    input  path_last,
    output path_ready
  );

endinterface

// File: rtl/path_stack.sv
// LIFO holding the path while it is traced back from destination to source.
// Flush has priority over push, push over pop; push when full and pop when empty are dropped.
module path_stack
  import path_extractor_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SP_WIDTH = sp_width(DEPTH)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic                i_flush,
  input  logic [WIDTH-1:0]    i_data,
  output logic [WIDTH-1:0]    o_top,
  output logic                o_full,
  output logic                o_empty,
  output logic [SP_WIDTH-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [SP_WIDTH-1:0] r_sp;
  logic [AW-1:0]       w_wr_idx;
  logic [AW-1:0]       w_top_idx;
  logic                w_do_push;

  assign o_full    = (r_sp == SP_WIDTH'(DEPTH));
  assign o_empty   = (r_sp == '0);
  assign o_count   = r_sp;
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_wr_idx  = AW'(r_sp);
  assign w_top_idx = AW'(r_sp - SP_WIDTH'(1));
  assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

  // Stack pointer: flush, push or pop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sp <= '0;
    end else if (i_flush) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_WIDTH'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_WIDTH'(1);
    end
  end

  // Entry storage; contents above the pointer are don't-care so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/path_extractor.sv
// Traces a shortest-path predecessor array prev[] in memory back from destination to source,
// then streams the nodes source-first. Memory bus outputs float (high-Z) when no read is active.
// Optional: define PATH_EXTRACTOR_LOOP_GUARD_EN to abort once a query would exceed N reads.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif

module path_extractor
  import path_extractor_pkg::*;
#(
  parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [INDEX_WIDTH-1:0] i_source,
  input  logic [INDEX_WIDTH-1:0] i_destination,
  input  logic [INDEX_WIDTH-1:0] i_number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] i_base_address,
  output tri                     o_mem_read_enable,
  output tri   [MADDR_WIDTH-1:0] o_mem_addr,
  input  logic                   i_mem_read_ready,
  input  logic [MDATA_WIDTH-1:0] i_mem_read_data,
  path_extractor_if.master       path,
  output logic [INDEX_WIDTH-1:0] o_path_length,
  output logic                   o_done,
  output logic                   o_error
);

  localparam int unsigned SP_WIDTH = sp_width(MAX_NODES);
  localparam int unsigned BYTES    = MADDR_WIDTH / 8;

  state_e                 r_state, w_state_next;
  logic [INDEX_WIDTH-1:0] r_src, r_dst, r_n, r_cur, r_prev, r_len;
  logic [MADDR_WIDTH-1:0] r_base;
  logic                   r_done, r_error;
  logic [INDEX_WIDTH-1:0] w_cur_next, w_len_next;
  logic                   w_done_next, w_error_next;
  logic                   w_latch, w_capture;
  logic                   w_push, w_pop, w_flush;
  logic [INDEX_WIDTH-1:0] w_push_data;
  logic [INDEX_WIDTH-1:0] w_top;
  logic                   w_full, w_empty;
  logic [SP_WIDTH-1:0]    w_count;
  logic                   w_rd_active;
  logic [MADDR_WIDTH-1:0] w_word, w_mem_addr;
  logic                   w_unused_data;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
  logic [INDEX_WIDTH:0]   r_reads, w_reads_next;
`endif

  path_stack #(
    .DEPTH    (MAX_NODES),
    .WIDTH    (INDEX_WIDTH),
    .SP_WIDTH (SP_WIDTH)
  ) u_stack (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_data    (w_push_data),
    .o_top     (w_top),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // prev[j] sits just past the N*N adjacency matrix, one word per entry.
  assign w_word     = MADDR_WIDTH'(r_n) * MADDR_WIDTH'(r_n) + MADDR_WIDTH'(r_cur);
  assign w_mem_addr = r_base + w_word * MADDR_WIDTH'(BYTES);
  assign w_rd_active = (r_state == StReq) || (r_state == StWait);

  assign o_mem_read_enable = w_rd_active ? 1'b1 : 1'bz;
  assign o_mem_addr        = w_rd_active ? w_mem_addr : {MADDR_WIDTH{1'bz}};

  // Only the low INDEX_WIDTH bits of a read word carry the predecessor.
  assign w_unused_data = ^i_mem_read_data;

  assign path.path_valid = (r_state == StEmit);
  assign path.path_node  = (r_state == StEmit) ? w_top : '0;
  assign path.path_last  = (r_state == StEmit) && (w_count == SP_WIDTH'(1));

  assign o_path_length = r_len;
  assign o_done        = r_done;
  assign o_error       = r_error;

  // Next-state and datapath control.
  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_len_next   = r_len;
    w_done_next  = r_done;
    w_error_next = r_error;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_push_data  = r_cur;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
    w_reads_next = r_reads;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_latch      = 1'b1;
          w_done_next  = 1'b0;
          w_error_next = 1'b0;
          w_len_next   = '0;
          w_flush      = 1'b1;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
          w_reads_next = '0;
`endif
          w_state_next = StCheck;
        end
      end
      StCheck: begin
        if ((r_dst >= r_n) || (r_src >= r_n)) begin
          w_state_next = StError;
        end else begin
          w_push       = 1'b1;
          w_push_data  = r_dst;
          w_cur_next   = r_dst;
          w_state_next = (r_dst == r_src) ? StEmit : StReq;
        end
      end
      StReq: begin
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
        w_reads_next = r_reads + (INDEX_WIDTH + 1)'(1);
`endif
        w_state_next = StWait;
      end
      StWait: begin
        if (i_mem_read_ready) begin
          w_capture    = 1'b1;
          w_state_next = StPush;
        end
      end
      StPush: begin
        // Out-of-range predecessor means destination is unreachable.
        if ((r_prev >= r_n) || w_full) begin
          w_state_next = StError;
        end else begin
          w_push      = 1'b1;
          w_push_data = r_prev;
          w_cur_next  = r_prev;
          if (r_prev == r_src) begin
            w_state_next = StEmit;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
          end else if (r_reads >= {1'b0, r_n}) begin
            w_state_next = StError;
`endif
          end else begin
            w_state_next = StReq;
          end
        end
      end
      StEmit: begin
        if (path.path_ready) begin
          w_pop      = 1'b1;
          w_len_next = r_len + INDEX_WIDTH'(1);
          if (w_count == SP_WIDTH'(1)) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      StError: begin
        w_flush      = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    // Flags become visible in the DONE/ERROR cycle itself and stay until the next start.
    if (w_state_next == StDone && r_state != StDone) begin
      w_done_next = 1'b1;
    end
    if (w_state_next == StError && r_state != StError) begin
      w_error_next = 1'b1;
    end
  end

  // State, query latches and status registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_n     <= '0;
      r_base  <= '0;
      r_cur   <= '0;
      r_prev  <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
      r_reads <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cur   <= w_cur_next;
      r_len   <= w_len_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
`ifdef PATH_EXTRACTOR_LOOP_GUARD_EN
      r_reads <= w_reads_next;
`endif
      if (w_latch) begin
        r_src  <= i_source;
        r_dst  <= i_destination;
        r_n    <= i_number_of_nodes;
        r_base <= i_base_address;
      end
      if (w_capture) begin
        r_prev <= i_mem_read_data[INDEX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_path_extractor.sv
// Directed bench for path_extractor: N=8, base=0, prev[] served by a small memory model.
module tb_path_extractor;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] source, destination, number_of_nodes;
  logic [AW-1:0] base_address;
  wire           mem_en;
  wire  [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_data;
  logic [IW-1:0] path_length;
  logic          done, error;

  path_extractor_if #(.INDEX_WIDTH(IW)) pbus ();

  path_extractor #(
    .MADDR_WIDTH (AW),
    .MDATA_WIDTH (DW),
    .MAX_NODES   (8),
    .INDEX_WIDTH (IW)
  ) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_start           (start),
    .i_source          (source),
    .i_destination     (destination),
    .i_number_of_nodes (number_of_nodes),
    .i_base_address    (base_address),
    .o_mem_read_enable (mem_en),
    .o_mem_addr        (mem_addr),
    .i_mem_read_ready  (mem_ready),
    .i_mem_read_data   (mem_data),
    .path              (pbus),
    .o_path_length     (path_length),
    .o_done            (done),
    .o_error           (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  logic [IW-1:0] prev_mem [8];
  int            read_cnt;
  logic [AW-1:0] first_addr;
  bit            en_q;
  int            valid_cnt;
  int            stall_bad;
  bit            stalled;
  logic [IW-1:0] stalled_node;
  logic [IW-1:0] node_q [$];
  bit            last_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: ready on every other cycle while enable is high; upper data bits are junk.
  always @(posedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      if (!en_q) begin
        read_cnt++;
        if (read_cnt == 1) first_addr = mem_addr;
      end
      en_q = 1'b1;
      if (!mem_ready) begin
        mem_ready = 1'b1;
        if (mem_addr >= 16'd128 && mem_addr < 16'd144)
          mem_data = 16'hABC0 | DW'(prev_mem[(mem_addr - 16'd128) >> 1]);
        else
          mem_data = 16'hFFFF;
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      en_q      = 1'b0;
      mem_ready = 1'b0;
    end
  end

  // Stream monitor: collect handshaken nodes and watch path_node during stalls.
  always @(negedge clk) begin
    if (rst_n && pbus.path_valid === 1'b1) begin
      valid_cnt++;
      if (stalled && pbus.path_node !== stalled_node) stall_bad++;
      if (pbus.path_ready === 1'b1) begin
        node_q.push_back(pbus.path_node);
        last_q.push_back(pbus.path_last);
        stalled = 1'b0;
      end else begin
        stalled      = 1'b1;
        stalled_node = pbus.path_node;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic set_basic();
    prev_mem[0] = 4'd0; prev_mem[1] = 4'd0; prev_mem[2] = 4'd1; prev_mem[3] = 4'd1;
    prev_mem[4] = 4'd2; prev_mem[5] = 4'd3; prev_mem[6] = 4'd4; prev_mem[7] = 4'd5;
  endtask

  task automatic launch(input logic [IW-1:0] src, input logic [IW-1:0] dst);
    @(negedge clk);
    read_cnt  = 0;
    valid_cnt = 0;
    stall_bad = 0;
    node_q.delete();
    last_q.delete();
    source      = src;
    destination = dst;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input bit toggle, input string tag);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk);
      #2;
      if (toggle) pbus.path_ready = ~pbus.path_ready;
      if (done === 1'b1 || error === 1'b1) fin = 1'b1;
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_basic_stream(input string tag);
    logic [IW-1:0] exp_nodes [5];
    exp_nodes[0] = 4'd0; exp_nodes[1] = 4'd1; exp_nodes[2] = 4'd3;
    exp_nodes[3] = 4'd5; exp_nodes[4] = 4'd7;
    check({tag, "_count"}, 32'(node_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < node_q.size()) begin
        check($sformatf("%s_node%0d", tag, i), 32'(node_q[i]), 32'(exp_nodes[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), (i == 4) ? 32'd1 : 32'd0);
      end
    end
    check({tag, "_length"}, 32'(path_length), 32'd5);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    source          = '0;
    destination     = '0;
    number_of_nodes = 4'd8;
    base_address    = '0;
    mem_ready       = 1'b0;
    mem_data        = '0;
    pbus.path_ready = 1'b1;
    en_q            = 1'b0;
    stalled         = 1'b0;
    stalled_node    = '0;
    read_cnt        = 0;
    valid_cnt       = 0;
    stall_bad       = 0;
    first_addr      = '0;
    set_basic();
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_valid", 32'(pbus.path_valid), 32'd0);
    check("rst_last", 32'(pbus.path_last), 32'd0);
    check("rst_node", 32'(pbus.path_node), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_length", 32'(path_length), 32'd0);
    check("rst_en_z", 32'(mem_en === 1'bz), 32'd1);
    check("rst_addr_z", 32'(mem_addr === 16'bz), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic path 7 -> 5 -> 3 -> 1 -> 0, streamed source first.
    launch(4'd0, 4'd7);
    wait_end(1'b0, "basic");
    check_basic_stream("basic");
    check("basic_reads", 32'(read_cnt), 32'd4);
    check("basic_first_addr", 32'(first_addr), 32'd142);
    check("basic_idle_en_z", 32'(mem_en === 1'bz), 32'd1);

    // Source equals destination: one node, no reads.
    launch(4'd3, 4'd3);
    wait_end(1'b0, "single");
    check("single_count", 32'(node_q.size()), 32'd1);
    if (node_q.size() == 1) begin
      check("single_node", 32'(node_q[0]), 32'd3);
      check("single_last", 32'(last_q[0]), 32'd1);
    end
    check("single_length", 32'(path_length), 32'd1);
    check("single_reads", 32'(read_cnt), 32'd0);
    check("single_done", 32'(done), 32'd1);

    // Unreachable: prev[7] out of range.
    prev_mem[7] = 4'd8;
    launch(4'd0, 4'd7);
    wait_end(1'b0, "unreach");
    check("unreach_error", 32'(error), 32'd1);
    check("unreach_done", 32'(done), 32'd0);
    check("unreach_valid", 32'(valid_cnt), 32'd0);
    check("unreach_reads", 32'(read_cnt), 32'd1);

    // Cycle 7 <-> 5: the eighth read either trips the guard or overflows the stack.
    prev_mem[7] = 4'd5;
    prev_mem[5] = 4'd7;
    launch(4'd0, 4'd7);
    wait_end(1'b0, "cycle");
    check("cycle_error", 32'(error), 32'd1);
    check("cycle_done", 32'(done), 32'd0);
    check("cycle_valid", 32'(valid_cnt), 32'd0);
    check("cycle_reads", 32'(read_cnt), 32'd8);
    set_basic();

    // Source out of range.
    launch(4'd9, 4'd2);
    wait_end(1'b0, "badsrc");
    check("badsrc_error", 32'(error), 32'd1);
    check("badsrc_reads", 32'(read_cnt), 32'd0);

    // Backpressure: path_ready toggles every cycle.
    launch(4'd0, 4'd7);
    wait_end(1'b1, "bp");
    check_basic_stream("bp");
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    pbus.path_ready = 1'b1;

    // Reset while stalled in EMIT, then a normal run.
    pbus.path_ready = 1'b0;
    launch(4'd0, 4'd7);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (pbus.path_valid === 1'b1) seen = 1'b1;
      end
      check("rstmid_reached_emit", 32'(seen), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(pbus.path_valid), 32'd0);
    check("rstmid_last", 32'(pbus.path_last), 32'd0);
    check("rstmid_node", 32'(pbus.path_node), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_error", 32'(error), 32'd0);
    check("rstmid_en_z", 32'(mem_en === 1'bz), 32'd1);
    check("rstmid_addr_z", 32'(mem_addr === 16'bz), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pbus.path_ready = 1'b1;
    launch(4'd0, 4'd7);
    wait_end(1'b0, "after");
    check_basic_stream("after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_extractor.md
PATH_EXTRACTOR -- requirements
Module: path_extractor

Interface
REQ-001 SHALL have parameter MADDR_WIDTH, default `DEFAULT_MADDR_WIDTH, which sets the memory address width.
REQ-002 SHALL have parameter MDATA_WIDTH, default `DEFAULT_MDATA_WIDTH, which sets the memory data width.
REQ-003 SHALL have parameter MAX_NODES, default `DEFAULT_MAX_NODES, which sets the maximum graph size and the stack depth.
REQ-004 SHALL have parameter INDEX_WIDTH, default `DEFAULT_INDEX_WIDTH, which sets the node index width.
REQ-005 SHALL have these ports, one clock and asynchronous active-low reset:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle start pulse, sampled in IDLE only.
- source, destination, number_of_nodes  in  INDEX_WIDTH each  path query and graph size N.
- base_address  in  MADDR_WIDTH  base of the adjacency matrix.
- mem_read_enable  out(tri)  1  read request.
- mem_addr  out(tri)  MADDR_WIDTH  read address.
- mem_read_ready  in  1  read data valid.
- mem_read_data  in  MDATA_WIDTH  read data.
- path_valid / path_ready  out / in  1  node-stream handshake.
- path_node  out  INDEX_WIDTH  current path node.
- path_last  out  1  marks the destination node.
- path_length  out  INDEX_WIDTH  node count, valid when done=1.
- done, error  out  1 each  sticky until next start.

Function
REQ-006 SHALL read prev[j] at mem_addr = base_address + (N*N + j) * (MADDR_WIDTH/8), using the low INDEX_WIDTH bits of data.
REQ-007 SHALL drive mem_read_enable and mem_addr to high-Z outside states REQ/WAIT; it never writes.
REQ-008 Read handshake: enable and addr are held from REQ until the cycle mem_read_ready=1; data is captured that cycle; enable is released the next cycle; minimum 2 cycles per read.
REQ-009 FSM states: IDLE, CHECK, REQ, WAIT, PUSH, EMIT, DONE, ERROR.
REQ-010 IDLE + start -> CHECK; query inputs are latched; done, error and path_length are cleared.
REQ-011 CHECK behaviour:
- destination>=N or source>=N -> ERROR.
- otherwise push destination, cur=destination.
- cur==source -> EMIT.
- else -> REQ.
REQ-012 PUSH: prev>=N -> ERROR (unreachable). Otherwise push prev and set cur=prev. Then cur==source -> EMIT, else REQ.
REQ-013 A push when the stack already holds MAX_NODES entries SHALL go to ERROR with nothing emitted.
REQ-014 EMIT pops in LIFO order, so the output runs source first and destination last:
- path_valid=1 and path_node=top of stack.
- pop only on a cycle where path_valid&&path_ready.
- path_node held stable while stalled.
- path_last=1 on the final entry.
REQ-015 After the last handshake -> DONE: done=1, path_length=nodes emitted, return to IDLE next cycle with done held.
REQ-016 ERROR: error=1, path_valid=0, stack flushed, return to IDLE next cycle.
REQ-017 start outside IDLE SHALL be ignored.

Reset
REQ-018 On reset low, asynchronously:
- state=IDLE, stack empty.
- path_valid, path_last, done, error = 0; path_node, path_length = 0.
- mem_read_enable and mem_addr = high-Z.
REQ-019 Reset mid-read or mid-emit SHALL abandon the operation with no further memory requests.

Configuration
REQ-020 With PATH_EXTRACTOR_LOOP_GUARD_EN defined, a read counter SHALL force ERROR when a read would exceed N reads, catching cycles in prev.
REQ-021 Without PATH_EXTRACTOR_LOOP_GUARD_EN, the counter is absent and cycles are caught only by the stack-full rule (REQ-013).

Structure
REQ-022 The state enum and stack pointer width SHALL live in a shared package; width defaults stay in constants.v.
REQ-023 A sub-module path_stack SHALL hold the LIFO: depth MAX_NODES, push/pop/flush, full/empty, top.

Verification
REQ-024 The bench SHALL cover these scenarios (N=8, base=0):
- Basic path: prev={0,0,1,1,2,3,4,5}, src 0, dst 7, path_ready=1 -> nodes 0,1,3,5,7; last on 7; length 5; done=1; 4 reads.
- src=dst=3 -> single node 3 with last=1, length 1, zero reads.
- Unreachable: prev[7]=8 -> error=1, no path_valid, done=0.
- Cycle, guard on: prev[7]=5, prev[5]=7, src 0 -> error after 8 reads. Guard off: error on stack full.
- Backpressure: path_ready toggled 1/0 on the basic path -> same sequence, path_node stable while stalled.
- Reset low mid-EMIT -> all outputs at reset values, bus high-Z; a following start completes normally.
